// File: rtl/sar_pkg.sv
// Shared constants for the successive-approximation search controller:
// FSM state encoding and the default operand width.
package sar_pkg;

  localparam int SAR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRIAL = 2'b01,
    FIN   = 2'b10
  } sar_state_t;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation controller wrapped around a magnitude comparator.
// Optional macro SAR_EARLY_EXIT_EN: finish as soon as the comparator reports EQ.
module sar_search
  import sar_pkg::*;
#(
  parameter int W = SAR_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         LG,
  input  logic         EQ,
  input  logic         RG,
  output logic [W-1:0] Y,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] RESULT,
  output logic         ERR,
  output logic [1:0]   dbg_state
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;

  // START is a level request with no ready: it is sampled only while IDLE,
  // and any START seen in TRIAL or FIN is dropped rather than queued.

  sar_state_t    state;
  logic [W-1:0]  acc;
  logic [KW-1:0] k;
  logic [W-1:0]  trial;
  logic [W-1:0]  acc_upd;
  logic          flags_ok;

  always_comb begin
    trial    = acc | (W'(1) << k);
    acc_upd  = RG ? acc : trial;
    flags_ok = 1'b0;
    case ({LG, EQ, RG})
      3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
      default:                flags_ok = 1'b0;
    endcase
  end

  // Outputs decode registered state only; the flags never reach them directly.
  assign Y         = (state == TRIAL) ? trial : '0;
  assign BUSY      = (state == TRIAL);
  assign DONE      = (state == FIN);
  assign dbg_state = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      acc    <= '0;
      k      <= KW'(W - 1);
      RESULT <= '0;
      ERR    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state <= TRIAL;
            acc   <= '0;
            k     <= KW'(W - 1);
            ERR   <= 1'b0;
          end
        end
        TRIAL: begin
          if (!flags_ok) begin
            ERR   <= 1'b1;
            state <= IDLE;
`ifdef SAR_EARLY_EXIT_EN
          end else if (EQ) begin
            acc    <= trial;
            RESULT <= trial;
            state  <= FIN;
`endif
          end else begin
            acc <= acc_upd;
            if (k == '0) begin
              RESULT <= acc_upd;
              state  <= FIN;
            end else begin
              k <= k - 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
